// File: rtl/cpu_pkg.sv
// Shared constants for the CPU datapath register file.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/register_file_if.sv
// Register file bus: two read ports, one write port and the debug write counter.
interface register_file_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);

    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [15:0]       write_count;

    // Datapath side: drives addresses and write data, consumes read data.
    modport master (
        output read_reg1, read_reg2, write_reg, write_data, reg_write,
        input  read_data1, read_data2, write_count
    );

    // Register file side.
    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, reg_write,
        output read_data1, read_data2, write_count
    );

endinterface

// File: rtl/register_file_reg_read_port.sv
// One combinational read port: zero-register force, write-through bypass, reset blanking.
module reg_read_port #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic                                 rst,
    input  logic [ADDR_W-1:0]                    rd_addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   regs,
    input  logic                                 wr_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    output logic [DATA_W-1:0]                    rd_data
);

    import cpu_pkg::*;

    // Address 0 and reset both read 0; a matching in-flight write is forwarded
    // so the consumer sees the value before the edge commits it.
    always_comb begin
        rd_data = '0;
        if (!rst && rd_addr != ADDR_W'(ZERO_REG)) begin
            if (wr_en && wr_addr == rd_addr)
                rd_data = wr_data;
            else
                rd_data = regs[rd_addr];
        end
    end

endmodule

// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file, two read ports with bypass, one write port.
module register_file #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);

    import cpu_pkg::*;

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [15:0]                  write_count_q, write_count_d;
    logic                         wr_commit;

    // Next-state: a write commits only when enabled and not aimed at register 0.
    always_comb begin
        wr_commit     = bus.reg_write && (bus.write_reg != ADDR_W'(ZERO_REG));
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (wr_commit) begin
            regs_d[bus.write_reg] = bus.write_data;
            write_count_d         = write_count_q + 16'd1;
        end
    end

    // Storage and counter; reset clears everything without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q        <= '0;
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port1 (
        .rst     (rst),
        .rd_addr (bus.read_reg1),
        .regs    (regs_q),
        .wr_en   (bus.reg_write),
        .wr_addr (bus.write_reg),
        .wr_data (bus.write_data),
        .rd_data (bus.read_data1)
    );

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port2 (
        .rst     (rst),
        .rd_addr (bus.read_reg2),
        .regs    (regs_q),
        .wr_en   (bus.reg_write),
        .wr_addr (bus.write_reg),
        .wr_data (bus.write_data),
        .rd_data (bus.read_data2)
    );

    assign bus.write_count = write_count_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, zero reg, bypass, async reset.
module tb_register_file;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    register_file #(.DATA_W(32), .ADDR_W(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edge, then settle 1ns before anything is sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.reg_write  = 1'b0;
        bus.write_reg  = '0;
        bus.write_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.read_reg1 = '0;
        bus.read_reg2 = '0;
        #2;
        for (int a = 0; a < 32; a++) begin
            bus.read_reg1 = 5'(a);
            bus.read_reg2 = 5'(31 - a);
            #1;
            tests++;
            if (bus.read_data1 !== 32'h0) begin
                fails++;
                $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", a, bus.read_data1, 32'h0);
            end
            tests++;
            if (bus.read_data2 !== 32'h0) begin
                fails++;
                $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", 31 - a, bus.read_data2, 32'h0);
            end
        end
        tests++;
        if (bus.write_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_count got=%0d exp=0", bus.write_count);
        end
        // Writes requested during reset must be ignored, bypass included.
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd4;
        bus.write_data = 32'h0BAD_0BAD;
        bus.read_reg1  = 5'd4;
        tick();
        tests++;
        if (bus.read_data1 !== 32'h0) begin
            fails++;
            $display("FAIL reset_bypass got=%h exp=%h", bus.read_data1, 32'h0);
        end
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        tests++;
        if (bus.read_data1 !== 32'h0 || bus.write_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_write_ignored rd1=%h cnt=%0d exp=0/0", bus.read_data1, bus.write_count);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd5;
        bus.write_data = 32'hDEADBEEF;
        tick();
        idle();
        bus.read_reg1 = 5'd5;
        bus.read_reg2 = 5'd6;
        #1;
        tests++;
        if (bus.read_data1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_read got=%h exp=%h", bus.read_data1, 32'hDEADBEEF);
        end
        tests++;
        if (bus.read_data2 !== 32'h0) begin
            fails++;
            $display("FAIL write_other_reg got=%h exp=%h", bus.read_data2, 32'h0);
        end
        tests++;
        if (bus.write_count !== 16'd1) begin
            fails++;
            $display("FAIL write_count1 got=%0d exp=1", bus.write_count);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd0;
        bus.write_data = 32'hFFFFFFFF;
        bus.read_reg2  = 5'd0;
        #1;
        tests++;
        if (bus.read_data2 !== 32'h0) begin
            fails++;
            $display("FAIL zero_no_bypass got=%h exp=%h", bus.read_data2, 32'h0);
        end
        tick();
        idle();
        #1;
        tests++;
        if (bus.read_data2 !== 32'h0) begin
            fails++;
            $display("FAIL zero_reg got=%h exp=%h", bus.read_data2, 32'h0);
        end
        tests++;
        if (bus.write_count !== 16'd1) begin
            fails++;
            $display("FAIL zero_count got=%0d exp=1", bus.write_count);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd9;
        bus.write_data = 32'h12345678;
        bus.read_reg1  = 5'd9;
        bus.read_reg2  = 5'd9;
        #1;
        tests++;
        if (bus.read_data1 !== 32'h12345678 || bus.read_data2 !== 32'h12345678) begin
            fails++;
            $display("FAIL bypass rd1=%h rd2=%h exp=%h", bus.read_data1, bus.read_data2, 32'h12345678);
        end
        // Bypass must not leak to a non-matching address.
        bus.read_reg2 = 5'd5;
        #1;
        tests++;
        if (bus.read_data2 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL bypass_nomatch got=%h exp=%h", bus.read_data2, 32'hDEADBEEF);
        end
        tick();
        idle();
        #1;
        tests++;
        if (bus.read_data1 !== 32'h12345678 || bus.write_count !== 16'd2) begin
            fails++;
            $display("FAIL bypass_commit rd1=%h cnt=%0d exp=%h/2", bus.read_data1, bus.write_count, 32'h12345678);
        end
    endtask

    task automatic test_enable_off();
        @(negedge clk);
        bus.reg_write  = 1'b0;
        bus.write_reg  = 5'd7;
        bus.write_data = 32'h1;
        bus.read_reg1  = 5'd7;
        #1;
        tests++;
        if (bus.read_data1 !== 32'h0) begin
            fails++;
            $display("FAIL enable_off_bypass got=%h exp=%h", bus.read_data1, 32'h0);
        end
        tick();
        tests++;
        if (bus.read_data1 !== 32'h0 || bus.write_count !== 16'd2) begin
            fails++;
            $display("FAIL enable_off rd1=%h cnt=%0d exp=0/2", bus.read_data1, bus.write_count);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd12;
        bus.write_data = 32'hAAAA0001;
        tick();
        bus.write_data = 32'hBBBB0002;
        tick();
        idle();
        bus.read_reg1 = 5'd12;
        bus.read_reg2 = 5'd12;
        #1;
        tests++;
        if (bus.read_data1 !== 32'hBBBB0002 || bus.read_data2 !== 32'hBBBB0002) begin
            fails++;
            $display("FAIL back_to_back rd1=%h rd2=%h exp=%h", bus.read_data1, bus.read_data2, 32'hBBBB0002);
        end
        tests++;
        if (bus.write_count !== 16'd4) begin
            fails++;
            $display("FAIL back_to_back_count got=%0d exp=4", bus.write_count);
        end
        // Earlier registers untouched by the burst.
        bus.read_reg1 = 5'd5;
        bus.read_reg2 = 5'd31;
        #1;
        tests++;
        if (bus.read_data1 !== 32'hDEADBEEF || bus.read_data2 !== 32'h0) begin
            fails++;
            $display("FAIL independent_ports rd1=%h rd2=%h exp=%h/%h", bus.read_data1, bus.read_data2, 32'hDEADBEEF, 32'h0);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd3;
        bus.write_data = 32'hA5A5A5A5;
        tick();
        idle();
        bus.read_reg1 = 5'd3;
        #1;
        tests++;
        if (bus.read_data1 !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL async_preload got=%h exp=%h", bus.read_data1, 32'hA5A5A5A5);
        end
        // Pending write, then a reset pulse between edges.
        @(negedge clk);
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd3;
        bus.write_data = 32'h5A5A5A5A;
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.read_data1 !== 32'h0) begin
            fails++;
            $display("FAIL async_reset_read got=%h exp=%h", bus.read_data1, 32'h0);
        end
        tests++;
        if (bus.write_count !== 16'd0) begin
            fails++;
            $display("FAIL async_reset_count got=%0d exp=0", bus.write_count);
        end
        idle();
        #1;
        rst = 1'b0;
        tick();
        tests++;
        if (bus.read_data1 !== 32'h0 || bus.write_count !== 16'd0) begin
            fails++;
            $display("FAIL async_write_dropped rd1=%h cnt=%0d exp=0/0", bus.read_data1, bus.write_count);
        end
        // First write after release lands on the first rising edge.
        @(negedge clk);
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd3;
        bus.write_data = 32'h0000_0C0D;
        tick();
        idle();
        #1;
        tests++;
        if (bus.read_data1 !== 32'h0000_0C0D || bus.write_count !== 16'd1) begin
            fails++;
            $display("FAIL post_reset_write rd1=%h cnt=%0d exp=%h/1", bus.read_data1, bus.write_count, 32'h0000_0C0D);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        idle();
        bus.read_reg1 = '0;
        bus.read_reg2 = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_enable_off();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout tests=%0d exp=finish", tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32, meaning register width in bits.
REQ-002 Parameter ADDR_W, default 5, meaning address width; register count is 2**ADDR_W (32).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 read_reg1  input  ADDR_W  read port 1 address (rs).
REQ-006 read_reg2  input  ADDR_W  read port 2 address (rt).
REQ-007 write_reg  input  ADDR_W  write address, driven by the 5-bit RegDst mux (rt/rd select).
REQ-008 write_data  input  DATA_W  write data (ALU result or memory load, from the MemtoReg mux).
REQ-009 reg_write  input  1  write enable.
REQ-010 read_data1  output  DATA_W  contents of read_reg1.
REQ-011 read_data2  output  DATA_W  contents of read_reg2.
REQ-012 write_count  output  16  number of committed non-zero-register writes since reset; debug counter.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits.
REQ-014 On a rising clk edge with reg_write=1 and write_reg!=0, register[write_reg] SHALL take write_data.
REQ-015 Writes with write_reg=0 SHALL be discarded; register 0 SHALL read 0 at all times.
REQ-016 With reg_write=0, no register SHALL change.
REQ-017 Reads SHALL be combinational, zero-cycle latency: read_dataN = register[read_regN].
REQ-018 Write-through bypass: when reg_write=1, write_reg!=0 and read_regN=write_reg, read_dataN SHALL equal write_data in the same cycle, before the edge.
REQ-019 Bypass SHALL never apply to address 0; read of address 0 during a write to 0 returns 0.
REQ-020 Both read ports SHALL be independent; same address on both returns identical data.
REQ-021 write_count SHALL increment by 1 on each edge where REQ-014 applies, and wrap from 16'hFFFF to 0.
REQ-022 Write to the same register on consecutive edges: last value wins; each edge counts once.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, clear all registers and write_count to 0.
REQ-024 While rst=1, writes SHALL be ignored, and read_data1/read_data2 SHALL be 0, bypass included.
REQ-025 Reset asserted mid-cycle while reg_write=1 SHALL drop that write; after deassertion, the first write SHALL occur on the first rising edge with rst=0.

Structure
REQ-026 A shared package cpu_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS and the constant ZERO_REG=0.
REQ-027 One sub-module, reg_read_port (address decode, zero-register force, bypass compare), SHALL be instantiated twice, once per read port.
REQ-028 Storage and write_count SHALL live in register_file; no latches; single always block for the array with async reset.

Verification
REQ-029 Reset: assert rst, read addresses 0..31 on both ports -> all 0, write_count=0.
REQ-030 Write/read: write_reg=5, write_data=32'hDEADBEEF, reg_write=1, one edge; read_reg1=5 -> 32'hDEADBEEF, write_count=1.
REQ-031 Zero register: write_reg=0, write_data=32'hFFFFFFFF, reg_write=1, edge; read_reg2=0 -> 0, write_count unchanged.
REQ-032 Bypass: reg_write=1, write_reg=9, write_data=32'h12345678, read_reg1=read_reg2=9 before edge -> both outputs 32'h12345678 combinationally.
REQ-033 Async reset mid-operation: reg 3 holds 32'hA5A5A5A5; pulse rst between edges -> read_reg1=3 returns 0 immediately, no clk edge needed; pending write is dropped.
REQ-034 Enable off: reg_write=0, write_reg=7, write_data=32'h1, edge -> reg 7 stays at its prior value, write_count unchanged.
